// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared types and helpers for the stopwatch control core.
//   state_t       : FSM state encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3)
//   time_t        : packed BCD time, minutes tens/ones, seconds tens/ones, tenths
//   DIGIT_MAX_9/5 : largest value a decimal / base-6 digit can hold
//   time_inc      : one-tenth increment with the full carry chain and wrap
//   time_is_max   : true when the time reads 59:59.9
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } time_t;

  localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [2:0] DIGIT_MAX_5 = 3'd5;

  // Advance the time by one tenth. Each digit rolls to zero and carries
  // into the next one up; carrying out of the minutes tens digit wraps
  // the whole time back to 00:00.0.
  function automatic time_t time_inc(input time_t t);
    time_t n;
    n = t;
    if (t.tenths != DIGIT_MAX_9) begin
      n.tenths = t.tenths + 4'd1;
    end else begin
      n.tenths = '0;
      if (t.sec_ones != DIGIT_MAX_9) begin
        n.sec_ones = t.sec_ones + 4'd1;
      end else begin
        n.sec_ones = '0;
        if (t.sec_tens != DIGIT_MAX_5) begin
          n.sec_tens = t.sec_tens + 3'd1;
        end else begin
          n.sec_tens = '0;
          if (t.min_ones != DIGIT_MAX_9) begin
            n.min_ones = t.min_ones + 4'd1;
          end else begin
            n.min_ones = '0;
            if (t.min_tens != DIGIT_MAX_5) begin
              n.min_tens = t.min_tens + 3'd1;
            end else begin
              n = '0;
            end
          end
        end
      end
    end
    return n;
  endfunction

  // The last representable time; the next tick from here is a rollover.
  function automatic logic time_is_max(input time_t t);
    return (t.min_tens == DIGIT_MAX_5) && (t.min_ones == DIGIT_MAX_9) &&
           (t.sec_tens == DIGIT_MAX_5) && (t.sec_ones == DIGIT_MAX_9) &&
           (t.tenths == DIGIT_MAX_9);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if
// Bundles the button inputs and the display/status outputs of the
// stopwatch core.
//   istart_stop, ilap_reset : button events into the core
//   omin_tens .. otenths    : BCD digits for the display path
//   ostate                  : current FSM state
//   otick, orollover        : single-cycle status pulses
// Modports: master drives the buttons and reads the display (board side
// or testbench); slave is the stopwatch core.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic       istart_stop;
  logic       ilap_reset;
  logic [2:0] omin_tens;
  logic [3:0] omin_ones;
  logic [2:0] osec_tens;
  logic [3:0] osec_ones;
  logic [3:0] otenths;
  state_t     ostate;
  logic       otick;
  logic       orollover;

  modport master (
    output istart_stop, ilap_reset,
    input  omin_tens, omin_ones, osec_tens, osec_ones, otenths,
    input  ostate, otick, orollover
  );

  modport slave (
    input  istart_stop, ilap_reset,
    output omin_tens, omin_ones, osec_tens, osec_ones, otenths,
    output ostate, otick, orollover
  );

endinterface

// File: rtl/stopwatch_tick_gen.sv
// stopwatch_tick_gen
// Prescaler that turns the board clock into a 0.1 s tick enable, so the
// whole stopwatch stays in the single board-clock domain.
//   iclk    : board clock
//   irst_n  : asynchronous active-low reset
//   ienable : count only while high (RUN or LAP); holding keeps the
//             partial tenth across a pause
//   iclear  : synchronous return of the prescaler to zero
//   otick   : high for the one cycle in which the prescaler sits at
//             DIVISOR-1 while enabled
// Parameters: DIVISOR cycles per tick, CNT_W prescaler width
// (2**CNT_W must be at least DIVISOR).
module stopwatch_tick_gen #(
  parameter int DIVISOR = 5000000,
  parameter int CNT_W   = 23
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic ienable,
  input  logic iclear,
  output logic otick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] count_q;

  // The tick is combinational off the count so the time counters can
  // advance on the very edge where the prescaler wraps.
  assign otick = ienable && (count_q == LAST);

  // Prescaler: clear wins, otherwise count up while enabled and wrap at
  // the last value; when disabled the count is simply held.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      count_q <= '0;
    end else if (iclear) begin
      count_q <= '0;
    end else if (ienable) begin
      if (count_q == LAST) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control and timekeeping core of the stopwatch: run/pause/lap/clear
// sequencing from two buttons, BCD minutes/seconds/tenths counting, and
// a registered display that shows either the live or the lap-frozen time.
//   iclk   : board clock, all logic on its rising edge
//   irst_n : asynchronous active-low reset
//   bus    : stopwatch_ctrl_if.slave (buttons in; digits, state, otick,
//            orollover out)
// Parameters: DIVISOR board-clock cycles per 0.1 s, CNT_W prescaler width.
// Build option STOPWATCH_EDGE_DETECT_EN: when defined, the buttons are
// level inputs passed through a 2-flop synchroniser and rising-edge
// detector (3 cycles of latency); when undefined they are taken as
// synchronous single-cycle pulses and used directly.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIVISOR = 5000000,
  parameter int CNT_W   = 23
) (
  input  logic             iclk,
  input  logic             irst_n,
  stopwatch_ctrl_if.slave  bus
);

  logic   start_evt;
  logic   lap_evt;
  logic   lap_only;
  state_t state_q, state_d;
  logic   capture_lap;
  logic   clear_time;
  logic   run_en;
  logic   tick;
  time_t  live_q, live_d;
  time_t  lap_q, lap_d;
  time_t  disp_q, disp_d;
  logic   tick_q;
  logic   rollover_q, rollover_d;

`ifdef STOPWATCH_EDGE_DETECT_EN
  logic [2:0] start_sync_q;
  logic [2:0] lap_sync_q;

  // Two synchroniser flops per button followed by a history flop; a
  // press becomes one event when the synchronised level first rises.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      start_sync_q <= '0;
      lap_sync_q   <= '0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], bus.istart_stop};
      lap_sync_q   <= {lap_sync_q[1:0], bus.ilap_reset};
    end
  end

  assign start_evt = start_sync_q[1] & ~start_sync_q[2];
  assign lap_evt   = lap_sync_q[1] & ~lap_sync_q[2];
`else
  assign start_evt = bus.istart_stop;
  assign lap_evt   = bus.ilap_reset;
`endif

  // Start/stop has priority, so a simultaneous lap/clear press is dropped.
  assign lap_only = lap_evt & ~start_evt;

  // Next-state logic. Besides the state, it flags the two side effects of
  // the lap/clear button: snapshotting the live time when entering LAP,
  // and clearing time plus prescaler when leaving PAUSE for IDLE.
  always_comb begin
    state_d     = state_q;
    capture_lap = 1'b0;
    clear_time  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_evt) state_d = RUN;
      end
      RUN: begin
        if (start_evt) begin
          state_d = PAUSE;
        end else if (lap_only) begin
          state_d     = LAP;
          capture_lap = 1'b1;
        end
      end
      PAUSE: begin
        if (start_evt) begin
          state_d = RUN;
        end else if (lap_only) begin
          state_d    = IDLE;
          clear_time = 1'b1;
        end
      end
      LAP: begin
        if (start_evt) begin
          state_d = PAUSE;
        end else if (lap_only) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counting follows the current (pre-transition) state, so a tick that
  // lands on the same edge as a stop is still applied.
  assign run_en = (state_q == RUN) || (state_q == LAP);

  stopwatch_tick_gen #(
    .DIVISOR (DIVISOR),
    .CNT_W   (CNT_W)
  ) u_tick_gen (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .ienable (run_en),
    .iclear  (clear_time),
    .otick   (tick)
  );

  // Next values for the live time, the lap snapshot and the display.
  // The display register is loaded from the next-cycle values so that the
  // digits change on the same edge as the registered tick/rollover pulses.
  always_comb begin
    live_d = live_q;
    if (clear_time) begin
      live_d = '0;
    end else if (tick) begin
      live_d = time_inc(live_q);
    end

    lap_d = lap_q;
    if (capture_lap) lap_d = live_q;

    disp_d     = (state_d == LAP) ? lap_d : live_d;
    rollover_d = tick && time_is_max(live_q);
  end

  // All state and output registers; reset returns everything to zero,
  // which is also the IDLE encoding.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q    <= IDLE;
      live_q     <= '0;
      lap_q      <= '0;
      disp_q     <= '0;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      lap_q      <= lap_d;
      disp_q     <= disp_d;
      tick_q     <= tick;
      rollover_q <= rollover_d;
    end
  end

  assign bus.omin_tens = disp_q.min_tens;
  assign bus.omin_ones = disp_q.min_ones;
  assign bus.osec_tens = disp_q.sec_tens;
  assign bus.osec_ones = disp_q.sec_ones;
  assign bus.otenths   = disp_q.tenths;
  assign bus.ostate    = state_q;
  assign bus.otick     = tick_q;
  assign bus.orollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Directed testbench for stopwatch_ctrl with DIVISOR=2, so one tenth is
// two clock cycles. The bench acts just after each falling edge: inputs
// driven there are sampled on the next rising edge and outputs read there
// are stable. Expected times are worked out by hand from the edge on
// which each button press is taken.
// Build option STOPWATCH_EDGE_DETECT_EN selects the level-input checks.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int failures = 0;
  int tick_count = 0;
  int roll_count = 0;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .DIVISOR (2),
    .CNT_W   (2)
  ) dut (
    .iclk   (clk),
    .irst_n (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Free-running pulse counters; tests take snapshots and compare deltas.
  always @(negedge clk) begin
    if (bus.otick === 1'b1) tick_count++;
    if (bus.orollover === 1'b1) roll_count++;
  end

  // Bound the whole run in case the design stalls the sequence somehow.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [17:0] disp_now();
    return {bus.omin_tens, bus.omin_ones, bus.osec_tens, bus.osec_ones, bus.otenths};
  endfunction

  function automatic logic [17:0] mk(int mt, int mo, int st, int so, int t);
    return {3'(mt), 4'(mo), 3'(st), 4'(so), 4'(t)};
  endfunction

  function automatic string tstr(logic [17:0] v);
    return $sformatf("%0d%0d:%0d%0d.%0d", v[17:15], v[14:11], v[10:8], v[7:4], v[3:0]);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.istart_stop = 1'b0;
    bus.ilap_reset  = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // Drive the buttons for exactly one rising edge.
  task automatic press(input logic s, input logic l);
    bus.istart_stop = s;
    bus.ilap_reset  = l;
    step(1);
    bus.istart_stop = 1'b0;
    bus.ilap_reset  = 1'b0;
  endtask

  task automatic test_reset();
    bus.istart_stop = 1'b0;
    bus.ilap_reset  = 1'b0;
    rst_n = 1'b0;
    step(2);
    checks++;
    if (bus.ostate !== IDLE) begin
      failures++;
      $display("[TB] FAIL reset_state: got %0d expected 0", bus.ostate);
    end
    checks++;
    if (disp_now() !== mk(0,0,0,0,0)) begin
      failures++;
      $display("[TB] FAIL reset_digits: got %s expected 00:00.0", tstr(disp_now()));
    end
    checks++;
    if ({bus.otick, bus.orollover} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_pulses: got %b expected 00", {bus.otick, bus.orollover});
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_run();
    int base;
    do_reset();
    base = tick_count;
    press(1'b1, 1'b0);
    checks++;
    if (bus.ostate !== RUN) begin
      failures++;
      $display("[TB] FAIL run_state: got %0d expected 1", bus.ostate);
    end
    step(20);
    checks++;
    if (disp_now() !== mk(0,0,0,1,0)) begin
      failures++;
      $display("[TB] FAIL run_20cyc: got %s expected 00:01.0", tstr(disp_now()));
    end
    checks++;
    if (tick_count - base !== 10) begin
      failures++;
      $display("[TB] FAIL run_ticks: got %0d expected 10", tick_count - base);
    end
  endtask

  task automatic test_pause_resume();
    int base;
    do_reset();
    press(1'b1, 1'b0);
    step(10);
    checks++;
    if (disp_now() !== mk(0,0,0,0,5)) begin
      failures++;
      $display("[TB] FAIL pause_pre: got %s expected 00:00.5", tstr(disp_now()));
    end
    press(1'b1, 1'b0);
    base = tick_count;
    step(50);
    checks++;
    if (bus.ostate !== PAUSE) begin
      failures++;
      $display("[TB] FAIL pause_state: got %0d expected 2", bus.ostate);
    end
    checks++;
    if (disp_now() !== mk(0,0,0,0,5) || tick_count != base) begin
      failures++;
      $display("[TB] FAIL pause_hold: got %s ticks %0d expected 00:00.5 ticks 0", tstr(disp_now()), tick_count - base);
    end
    press(1'b1, 1'b0);
    checks++;
    if (bus.ostate !== RUN || disp_now() !== mk(0,0,0,0,5)) begin
      failures++;
      $display("[TB] FAIL resume_edge: got state %0d %s expected 1 00:00.5", bus.ostate, tstr(disp_now()));
    end
    step(1);
    checks++;
    if (disp_now() !== mk(0,0,0,0,6) || bus.otick !== 1'b1) begin
      failures++;
      $display("[TB] FAIL resume_partial: got %s otick %b expected 00:00.6 otick 1", tstr(disp_now()), bus.otick);
    end
  endtask

  task automatic test_lap();
    do_reset();
    press(1'b1, 1'b0);
    step(46);
    checks++;
    if (disp_now() !== mk(0,0,0,2,3)) begin
      failures++;
      $display("[TB] FAIL lap_pre: got %s expected 00:02.3", tstr(disp_now()));
    end
    press(1'b0, 1'b1);
    checks++;
    if (bus.ostate !== LAP || disp_now() !== mk(0,0,0,2,3)) begin
      failures++;
      $display("[TB] FAIL lap_enter: got state %0d %s expected 3 00:02.3", bus.ostate, tstr(disp_now()));
    end
    step(39);
    checks++;
    if (disp_now() !== mk(0,0,0,2,3)) begin
      failures++;
      $display("[TB] FAIL lap_frozen: got %s expected 00:02.3", tstr(disp_now()));
    end
    press(1'b0, 1'b1);
    checks++;
    if (bus.ostate !== RUN || disp_now() !== mk(0,0,0,4,3)) begin
      failures++;
      $display("[TB] FAIL lap_release: got state %0d %s expected 1 00:04.3", bus.ostate, tstr(disp_now()));
    end
  endtask

  task automatic test_simultaneous_clear();
    do_reset();
    press(1'b1, 1'b0);
    step(74);
    press(1'b1, 1'b0);
    checks++;
    if (bus.ostate !== PAUSE || disp_now() !== mk(0,0,0,3,7)) begin
      failures++;
      $display("[TB] FAIL simul_pause: got state %0d %s expected 2 00:03.7", bus.ostate, tstr(disp_now()));
    end
    press(1'b1, 1'b1);
    checks++;
    if (bus.ostate !== RUN || disp_now() !== mk(0,0,0,3,7)) begin
      failures++;
      $display("[TB] FAIL simul_priority: got state %0d %s expected 1 00:03.7", bus.ostate, tstr(disp_now()));
    end
    step(1);
    checks++;
    if (disp_now() !== mk(0,0,0,3,8)) begin
      failures++;
      $display("[TB] FAIL simul_continue: got %s expected 00:03.8", tstr(disp_now()));
    end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (bus.ostate !== IDLE || disp_now() !== mk(0,0,0,0,0)) begin
      failures++;
      $display("[TB] FAIL clear: got state %0d %s expected 0 00:00.0", bus.ostate, tstr(disp_now()));
    end
    press(1'b0, 1'b1);
    checks++;
    if (bus.ostate !== IDLE) begin
      failures++;
      $display("[TB] FAIL idle_lap_ignored: got %0d expected 0", bus.ostate);
    end
    press(1'b1, 1'b0);
    step(1);
    checks++;
    if (disp_now() !== mk(0,0,0,0,0)) begin
      failures++;
      $display("[TB] FAIL prescaler_cleared: got %s expected 00:00.0", tstr(disp_now()));
    end
    step(1);
    checks++;
    if (disp_now() !== mk(0,0,0,0,1)) begin
      failures++;
      $display("[TB] FAIL restart_first_tick: got %s expected 00:00.1", tstr(disp_now()));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.istart_stop = 1'b1;
    step(1);
    checks++;
    if (bus.ostate !== RUN) begin
      failures++;
      $display("[TB] FAIL held_1: got %0d expected 1", bus.ostate);
    end
    step(1);
    checks++;
    if (bus.ostate !== PAUSE) begin
      failures++;
      $display("[TB] FAIL held_2: got %0d expected 2", bus.ostate);
    end
    step(1);
    bus.istart_stop = 1'b0;
    checks++;
    if (bus.ostate !== RUN) begin
      failures++;
      $display("[TB] FAIL held_3: got %0d expected 1", bus.ostate);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    press(1'b1, 1'b0);
    step(6);
    checks++;
    if (bus.otick !== 1'b1 || disp_now() !== mk(0,0,0,0,3)) begin
      failures++;
      $display("[TB] FAIL areset_pre: got %s otick %b expected 00:00.3 otick 1", tstr(disp_now()), bus.otick);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ostate !== IDLE || disp_now() !== mk(0,0,0,0,0) || bus.otick !== 1'b0 || bus.orollover !== 1'b0) begin
      failures++;
      $display("[TB] FAIL areset_immediate: got state %0d %s otick %b expected 0 00:00.0 otick 0", bus.ostate, tstr(disp_now()), bus.otick);
    end
    step(2);
    rst_n = 1'b1;
    step(2);
    checks++;
    if (bus.ostate !== IDLE || disp_now() !== mk(0,0,0,0,0) || bus.otick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL areset_after: got state %0d %s expected 0 00:00.0", bus.ostate, tstr(disp_now()));
    end
  endtask

  task automatic test_rollover();
    int base;
    do_reset();
    base = roll_count;
    press(1'b1, 1'b0);
    step(71998);
    checks++;
    if (disp_now() !== mk(5,9,5,9,9) || roll_count != base) begin
      failures++;
      $display("[TB] FAIL roll_pre: got %s rollovers %0d expected 59:59.9 rollovers 0", tstr(disp_now()), roll_count - base);
    end
    step(1);
    checks++;
    if (disp_now() !== mk(5,9,5,9,9) || bus.orollover !== 1'b0) begin
      failures++;
      $display("[TB] FAIL roll_wait: got %s orollover %b expected 59:59.9 0", tstr(disp_now()), bus.orollover);
    end
    step(1);
    checks++;
    if (disp_now() !== mk(0,0,0,0,0) || bus.otick !== 1'b1 || bus.orollover !== 1'b1) begin
      failures++;
      $display("[TB] FAIL roll_wrap: got %s otick %b orollover %b expected 00:00.0 1 1", tstr(disp_now()), bus.otick, bus.orollover);
    end
    step(1);
    checks++;
    if (bus.orollover !== 1'b0 || roll_count - base !== 1) begin
      failures++;
      $display("[TB] FAIL roll_single: got orollover %b count %0d expected 0 count 1", bus.orollover, roll_count - base);
    end
  endtask

`ifdef STOPWATCH_EDGE_DETECT_EN
  task automatic test_edge_detect();
    do_reset();
    bus.istart_stop = 1'b1;
    step(2);
    checks++;
    if (bus.ostate !== IDLE) begin
      failures++;
      $display("[TB] FAIL edge_latency: got %0d expected 0", bus.ostate);
    end
    step(1);
    checks++;
    if (bus.ostate !== RUN) begin
      failures++;
      $display("[TB] FAIL edge_first: got %0d expected 1", bus.ostate);
    end
    step(7);
    bus.istart_stop = 1'b0;
    step(4);
    checks++;
    if (bus.ostate !== RUN) begin
      failures++;
      $display("[TB] FAIL edge_held_once: got %0d expected 1", bus.ostate);
    end
    bus.istart_stop = 1'b1;
    step(1);
    bus.istart_stop = 1'b0;
    step(2);
    checks++;
    if (bus.ostate !== PAUSE) begin
      failures++;
      $display("[TB] FAIL edge_second: got %0d expected 2", bus.ostate);
    end
  endtask
`endif

  initial begin
    bus.istart_stop = 1'b0;
    bus.ilap_reset  = 1'b0;
    $display("[TB] stopwatch_ctrl directed test start");
    test_reset();
`ifdef STOPWATCH_EDGE_DETECT_EN
    test_edge_detect();
`else
    test_run();
    test_pause_resume();
    test_lap();
    test_simultaneous_clear();
    test_back_to_back();
    test_async_reset();
    test_rollover();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control and timekeeping core of the stopwatch. It derives a 10 Hz tick *enable* from the board clock, avoiding a generated clock domain. It sequences run, pause, lap and clear from two push-button inputs. It maintains BCD minutes/seconds/tenths counters and supplies the display path with either the live or the lap-frozen time.

Parameters:
DIVISOR, 5000000, board-clock cycles per 0.1 s tick (2 for simulation benches)
CNT_W, 23, prescaler width; must satisfy 2**CNT_W >= DIVISOR

Ports:
iclk  input  1  board clock, all logic on posedge
irst_n  input  1  asynchronous active-low reset
istart_stop  input  1  start/stop button (single-cycle pulse, or level if STOPWATCH_EDGE_DETECT_EN)
ilap_reset  input  1  lap/clear button (same convention)
omin_tens  output  3  minutes tens digit, 0-5
omin_ones  output  4  minutes ones digit, 0-9
osec_tens  output  3  seconds tens digit, 0-5
osec_ones  output  4  seconds ones digit, 0-9
otenths  output  4  tenths digit, 0-9
ostate  output  2  current FSM state encoding (stopwatch_pkg::state_t)
otick  output  1  single-cycle pulse on each 0.1 s increment
orollover  output  1  single-cycle pulse on wrap 59:59.9 -> 00:00.0

Behaviour:
- Reset (async assert, sync release): state IDLE, prescaler 0, live and lap registers all 0, all outputs 0.
- FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3.
- istart_stop transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN, LAP->PAUSE. On LAP->PAUSE the display returns to the live value.
- ilap_reset transitions:
  - RUN->LAP: copies the live time into the lap registers on the same edge.
  - LAP->RUN: releases the display.
  - PAUSE->IDLE: clears the live time and the prescaler.
  - IDLE: ignored.
- Simultaneous istart_stop and ilap_reset: istart_stop wins; ilap_reset is dropped.
- Prescaler behaviour:
  - Increments only in RUN or LAP.
  - Holds its value in PAUSE, so a resume preserves the partial tenth.
  - When it equals DIVISOR-1 it wraps to 0 and the internal tick is high for that cycle.
- Time counters: on a tick edge, tenths increments. Carry chain: tenths 9->0 carries to seconds ones; 9->0 carries to seconds tens; 5->0 carries to minutes ones; 9->0 carries to minutes tens; 5->0 wraps the whole time to 00:00.0.
- The time keeps counting in LAP; only the display is frozen.
- Output timing:
  - Digit outputs are registered and show the lap registers in LAP, otherwise the live registers.
  - Digit outputs change one cycle after the internal tick.
  - otick and orollover are registered and coincide with the digit update.
- The first tick after IDLE->RUN occurs DIVISOR cycles after the RUN edge.
- A transition out of RUN/LAP on the same edge as a tick: the tick is still applied (counter update uses the pre-transition state).
- Reset mid-run: immediate return to IDLE with all zeros; no pulse outputs.

Optional Feature:
STOPWATCH_EDGE_DETECT_EN
- Defined: istart_stop and ilap_reset are treated as level inputs. They pass through a 2-flop synchroniser plus rising-edge detector, so each press acts once. This adds 3 cycles of input latency.
- Undefined: the inputs are assumed already synchronous single-cycle pulses and are used directly; a held-high input toggles every cycle.

Decomposition:
- stopwatch_pkg holds:
  - state_t enum: IDLE, RUN, PAUSE, LAP
  - time_t packed struct: min_tens, min_ones, sec_tens, sec_ones, tenths
  - digit maxima constants: 9, 5
- One sub-module, stopwatch_tick_gen:
  - Parameters: DIVISOR, CNT_W.
  - Inputs: iclk, irst_n, ienable, iclear.
  - Output: otick.
  - Contains the prescaler.

Test Plan:
1. DIVISOR=2; reset, pulse istart_stop -> ostate=1; after 20 further cycles digits read 00:01.0, 10 otick pulses seen.
2. RUN to 00:00.5, pulse istart_stop, wait 50 cycles -> digits hold 00:00.5, ostate=2. Pulse istart_stop again -> next tick after 2 cycles if paused mid-count preserved.
3. RUN to 00:02.3, pulse ilap_reset -> display frozen at 00:02.3 for 40 cycles. Pulse ilap_reset -> display jumps to 00:04.3.
4. Preload-run to 59:59.9 (force or long run), one tick -> 00:00.0, orollover pulse exactly 1 cycle with otick.
5. PAUSE at 00:03.7, pulse istart_stop and ilap_reset same cycle -> RUN, time not cleared. Then pause, pulse ilap_reset -> IDLE, 00:00.0.
6. Assert irst_n=0 asynchronously mid-RUN between clock edges -> outputs 0 before next posedge; STOPWATCH_EDGE_DETECT_EN build: istart_stop held high 10 cycles -> single RUN transition.
